sint_dispatch: RTL and testbench

//  Parametrised scene-intersection dispatcher: admits rays from shader, tags them through a

---
 rtl/sint_dispatch_if.sv | 50 +++++
 rtl/sint_dispatch.sv | 146 ++++++++++++++
 tb/tb_sint_dispatch.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sint_dispatch_if.sv
// Request, slab-datapath and destination channels of sint_dispatch.
// The slave modport is the dispatcher's view; master is the surrounding system's view.
interface sint_dispatch_if #(
    parameter int ID_W = 8
);
    logic            in_valid;
    logic [ID_W-1:0] in_rayID;
    logic            in_shadow;
    logic            in_stall;

    logic            pl_issue;
    logic [31:0]     pl_tmin;
    logic [31:0]     pl_tmax;
    logic            pl_miss;

    logic            tarb_valid;
    logic [ID_W-1:0] tarb_rayID;
    logic            tarb_shadow;
    logic [31:0]     tarb_tmin;
    logic [31:0]     tarb_tmax;
    logic            tarb_stall;

    logic            ss_valid;
    logic [ID_W-1:0] ss_rayID;
    logic [31:0]     ss_tmax;
    logic            ss_stall;

    logic            sh_valid;
    logic [ID_W-1:0] sh_rayID;
    logic            sh_shadow;
    logic            sh_stall;

    modport slave (
        input  in_valid, in_rayID, in_shadow, pl_tmin, pl_tmax, pl_miss,
               tarb_stall, ss_stall, sh_stall,
        output in_stall, pl_issue,
               tarb_valid, tarb_rayID, tarb_shadow, tarb_tmin, tarb_tmax,
               ss_valid, ss_rayID, ss_tmax,
               sh_valid, sh_rayID, sh_shadow
    );

    modport master (
        output in_valid, in_rayID, in_shadow, pl_tmin, pl_tmax, pl_miss,
               tarb_stall, ss_stall, sh_stall,
        input  in_stall, pl_issue,
               tarb_valid, tarb_rayID, tarb_shadow, tarb_tmin, tarb_tmax,
               ss_valid, ss_rayID, ss_tmax,
               sh_valid, sh_rayID, sh_shadow
    );
endinterface

// File: rtl/sint_dispatch.sv
// Scene-intersection dispatcher: credit-gated admission, never-stalling tag pipe, three result FIFOs.
// Define SINT_STATS_EN to add saturating hit / miss / backpressure-cycle counters.
module sint_dispatch #(
    parameter int ID_W        = 8,
    parameter int LAT         = 18,
    parameter int DEPTH       = 16,
    parameter int SHADOW_NOSS = 1
) (
    input  logic           clk,
    input  logic           rst,
    sint_dispatch_if.slave bus
`ifdef SINT_STATS_EN
    ,
    output logic [31:0]    stat_hits,
    output logic [31:0]    stat_misses,
    output logic [31:0]    stat_bp_cycles
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + LAT + 1) + 2;
    localparam logic [PW:0]          P_ONE   = (PW+1)'(1);
    localparam logic [PW:0]          P_FULL  = (PW+1)'(DEPTH);
    localparam logic [CW-1:0]        C_ONE   = CW'(1);
    localparam logic signed [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam bit                   NOSS    = (SHADOW_NOSS != 0);

    logic                 acc;
    logic                 no_cred;
    logic signed [CW-1:0] cred_avail;
    logic [CW-1:0]        pipe_cnt;
    logic [LAT-1:0]       vld_p;
    logic [ID_W-1:0]      id_p  [LAT];
    logic                 shd_p [LAT];
    logic                 out_v;
    logic                 push_t, push_s, push_h;
    logic                 pop_t, pop_s, pop_h;
    logic [PW:0]          t_wp, t_rp, s_wp, s_rp, h_wp, h_rp;
    logic [PW:0]          occ_t, occ_s, occ_h, occ_max;
    logic [ID_W+64:0]     t_mem [DEPTH];
    logic [ID_W+31:0]     s_mem [DEPTH];
    logic [ID_W:0]        h_mem [DEPTH];

    assign occ_t = t_wp - t_rp;
    assign occ_s = s_wp - s_rp;
    assign occ_h = h_wp - h_rp;

    always_comb begin
        occ_max = occ_t;
        if (occ_s > occ_max) occ_max = occ_s;
        if (occ_h > occ_max) occ_max = occ_h;
    end

    // Credits left after everything in flight lands in the fullest FIFO.
    assign cred_avail   = C_DEPTH - pipe_cnt - CW'(occ_max);
    assign no_cred      = cred_avail[CW-1] | (cred_avail == '0);
    assign bus.in_stall = ~rst | (bus.in_valid & no_cred);
    assign acc          = bus.in_valid & ~bus.in_stall;
    assign bus.pl_issue = acc;

    // Stage 0 .. LAT-1: tag pipe, advances every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p    <= '0;
            pipe_cnt <= '0;
        end else begin
            vld_p[0] <= acc;
            for (int k = 1; k < LAT; k++) vld_p[k] <= vld_p[k-1];
            pipe_cnt <= pipe_cnt + (acc ? C_ONE : '0) - (out_v ? C_ONE : '0);
        end
    end

    always_ff @(posedge clk) begin
        id_p[0]  <= bus.in_rayID;
        shd_p[0] <= bus.in_shadow;
        for (int k = 1; k < LAT; k++) begin
            id_p[k]  <= id_p[k-1];
            shd_p[k] <= shd_p[k-1];
        end
    end

    // Stage LAT: datapath result joins its tag and is routed
    assign out_v  = vld_p[LAT-1];
    assign push_h = out_v & bus.pl_miss;
    assign push_t = out_v & ~bus.pl_miss;
    assign push_s = push_t & ~(NOSS & shd_p[LAT-1]);

    always_ff @(posedge clk) begin
        if (push_t) t_mem[t_wp[PW-1:0]] <= {id_p[LAT-1], shd_p[LAT-1], bus.pl_tmin, bus.pl_tmax};
        if (push_s) s_mem[s_wp[PW-1:0]] <= {id_p[LAT-1], bus.pl_tmax};
        if (push_h) h_mem[h_wp[PW-1:0]] <= {id_p[LAT-1], shd_p[LAT-1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_wp <= '0; t_rp <= '0;
            s_wp <= '0; s_rp <= '0;
            h_wp <= '0; h_rp <= '0;
        end else begin
            if (push_t) t_wp <= t_wp + P_ONE;
            if (pop_t)  t_rp <= t_rp + P_ONE;
            if (push_s) s_wp <= s_wp + P_ONE;
            if (pop_s)  s_rp <= s_rp + P_ONE;
            if (push_h) h_wp <= h_wp + P_ONE;
            if (pop_h)  h_rp <= h_rp + P_ONE;
        end
    end

    // Stage LAT+1: FIFO heads, no fall-through
    assign bus.tarb_valid = (occ_t != '0);
    assign bus.ss_valid   = (occ_s != '0);
    assign bus.sh_valid   = (occ_h != '0);
    assign pop_t = bus.tarb_valid & ~bus.tarb_stall;
    assign pop_s = bus.ss_valid & ~bus.ss_stall;
    assign pop_h = bus.sh_valid & ~bus.sh_stall;

    assign {bus.tarb_rayID, bus.tarb_shadow, bus.tarb_tmin, bus.tarb_tmax} = t_mem[t_rp[PW-1:0]];
    assign {bus.ss_rayID, bus.ss_tmax}   = s_mem[s_rp[PW-1:0]];
    assign {bus.sh_rayID, bus.sh_shadow} = h_mem[h_rp[PW-1:0]];

`ifdef SINT_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits      <= '0;
            stat_misses    <= '0;
            stat_bp_cycles <= '0;
        end else begin
            if (push_t && stat_hits != '1)   stat_hits   <= stat_hits + 32'd1;
            if (push_h && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
            if (bus.in_valid && bus.in_stall && stat_bp_cycles != '1)
                stat_bp_cycles <= stat_bp_cycles + 32'd1;
        end
    end
`endif

    a_full_write: assert property (@(posedge clk) disable iff (!rst)
        !((push_t && occ_t == P_FULL) || (push_s && occ_s == P_FULL) || (push_h && occ_h == P_FULL)))
        else $fatal(1, "sint_dispatch: write to full FIFO");

    a_cred_range: assert property (@(posedge clk) disable iff (!rst)
        !cred_avail[CW-1] && cred_avail <= C_DEPTH)
        else $fatal(1, "sint_dispatch: credit counter out of range");

    a_pl_stage: assert property (@(posedge clk) disable iff (!rst)
        (push_t || push_h) |-> out_v)
        else $fatal(1, "sint_dispatch: datapath result used with stage LAT invalid");
endmodule

// File: tb/tb_sint_dispatch.sv
// Directed bench for sint_dispatch: latency, routing, backpressure, independence, mid-flight
// reset and a randomised-stall stream checked against per-FIFO expected queues.
`timescale 1ns/1ps
module tb_sint_dispatch;
    localparam int ID_W        = 8;
    localparam int LAT         = 18;
    localparam int DEPTH       = 16;
    localparam int SHADOW_NOSS = 1;
    localparam int NRAND       = 10000;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            sh;
        logic [31:0]     tmin;
        logic [31:0]     tmax;
    } ent_t;

    typedef struct packed {
        logic        iss;
        logic        miss;
        logic [31:0] tmin;
        logic [31:0] tmax;
    } dp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          ncmp = 0;
    int          nfail = 0;
    int          n_acc = 0;
    int          n_bp = 0;
    int          rst_acc = 0;
    logic        cur_miss;
    logic [31:0] cur_tmin, cur_tmax;
    ent_t        qt[$], qs[$], qh[$];
    dp_t         dp [LAT];

    sint_dispatch_if #(.ID_W(ID_W)) bus ();

`ifdef SINT_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_bp_cycles;
`endif

    sint_dispatch #(.ID_W(ID_W), .LAT(LAT), .DEPTH(DEPTH), .SHADOW_NOSS(SHADOW_NOSS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SINT_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses),
        .stat_bp_cycles (stat_bp_cycles)
`endif
    );

    always #5 clk = ~clk;

    // External slab-test datapath: result appears LAT cycles after the issue strobe.
    always @(posedge clk) begin
        dp[0] <= {bus.pl_issue, cur_miss, cur_tmin, cur_tmax};
        for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
    end
    assign bus.pl_miss = dp[LAT-1].miss;
    assign bus.pl_tmin = dp[LAT-1].tmin;
    assign bus.pl_tmax = dp[LAT-1].tmax;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        ncmp++;
        assert (obs === req) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic offer(input logic [ID_W-1:0] id, input logic sh, input logic miss,
                         input logic [31:0] tmin, input logic [31:0] tmax);
        bus.in_valid  = 1'b1;
        bus.in_rayID  = id;
        bus.in_shadow = sh;
        cur_miss      = miss;
        cur_tmin      = tmin;
        cur_tmax      = tmax;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Record the transfers that complete at the coming edge, then advance one cycle.
    task automatic tick();
        ent_t e;
        #1;
        if (bus.in_valid && bus.in_stall) n_bp++;
        if (bus.pl_issue) begin
            n_acc++;
            e = {bus.in_rayID, bus.in_shadow, cur_tmin, cur_tmax};
            if (cur_miss) qh.push_back(e);
            else begin
                qt.push_back(e);
                if (!(SHADOW_NOSS != 0 && e.sh)) qs.push_back(e);
            end
        end
        if (bus.tarb_valid && !bus.tarb_stall) begin
            chk("tarb_expected", qt.size() != 0, 1);
            if (qt.size() != 0) begin
                e = qt.pop_front();
                chk("tarb_rayID", bus.tarb_rayID, e.id);
                chk("tarb_shadow", bus.tarb_shadow, e.sh);
                chk("tarb_tmin", bus.tarb_tmin, e.tmin);
                chk("tarb_tmax", bus.tarb_tmax, e.tmax);
            end
        end
        if (bus.ss_valid && !bus.ss_stall) begin
            chk("ss_expected", qs.size() != 0, 1);
            if (qs.size() != 0) begin
                e = qs.pop_front();
                chk("ss_rayID", bus.ss_rayID, e.id);
                chk("ss_tmax", bus.ss_tmax, e.tmax);
            end
        end
        if (bus.sh_valid && !bus.sh_stall) begin
            chk("sh_expected", qh.size() != 0, 1);
            if (qh.size() != 0) begin
                e = qh.pop_front();
                chk("sh_rayID", bus.sh_rayID, e.id);
                chk("sh_shadow", bus.sh_shadow, e.sh);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        idle();
        bus.tarb_stall = 1'b0;
        bus.ss_stall   = 1'b0;
        bus.sh_stall   = 1'b0;
        for (int c = 0; c < 400 && (qt.size() + qs.size() + qh.size()) != 0; c++) tick();
        repeat (2) tick();
        chk({tag, "_drained"}, qt.size() + qs.size() + qh.size(), 0);
    endtask

    initial begin
        int base, bp0, cnt;
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_rayID   = '0;
        bus.in_shadow  = 1'b0;
        bus.tarb_stall = 1'b0;
        bus.ss_stall   = 1'b0;
        bus.sh_stall   = 1'b0;
        cur_miss       = 1'b0;
        cur_tmin       = '0;
        cur_tmax       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_stall", bus.in_stall, 1);
        chk("reset_outputs", {bus.tarb_valid, bus.ss_valid, bus.sh_valid, bus.pl_issue}, 0);
        rst = 1'b1;
        #1;
        chk("idle_in_stall", bus.in_stall, 0);

        // Single hit: ray 0x05, tmin 1.0, tmax 4.0
        offer(8'h05, 1'b0, 1'b0, 32'h3F80_0000, 32'h4080_0000);
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk("hit_tarb_early", bus.tarb_valid, 0);
        chk("hit_ss_early", bus.ss_valid, 0);
        tick();
        chk("hit_tarb_valid", bus.tarb_valid, 1);
        chk("hit_ss_valid", bus.ss_valid, 1);
        chk("hit_tarb_rayID", bus.tarb_rayID, 8'h05);
        chk("hit_tarb_tmin", bus.tarb_tmin, 32'h3F80_0000);
        chk("hit_tarb_tmax", bus.tarb_tmax, 32'h4080_0000);
        chk("hit_ss_tmax", bus.ss_tmax, 32'h4080_0000);
        drain("hit");

        // Shadow miss goes to the shader only
        offer(8'h0A, 1'b1, 1'b1, $urandom, $urandom);
        tick();
        idle();
        repeat (LAT) tick();
        chk("miss_sh_valid", bus.sh_valid, 1);
        chk("miss_sh_rayID", bus.sh_rayID, 8'h0A);
        chk("miss_sh_shadow", bus.sh_shadow, 1);
        chk("miss_tarb_ss_empty", {bus.tarb_valid, bus.ss_valid}, 0);
        drain("miss");

        // Shadow hit skips SS
        offer(8'h0B, 1'b1, 1'b0, $urandom, $urandom);
        tick();
        idle();
        repeat (LAT) tick();
        chk("shit_tarb_valid", bus.tarb_valid, 1);
        chk("shit_tarb_shadow", bus.tarb_shadow, 1);
        chk("shit_ss_valid", bus.ss_valid, 0);
        drain("shadow_hit");

        // SS backpressure: exactly DEPTH admitted, then stall; release drains all 40 in order
        bus.ss_stall = 1'b1;
        base = n_acc;
        for (int c = 0; c < 60; c++) begin
            offer(8'(32'h20 + n_acc - base), 1'b0, 1'b0, $urandom, $urandom);
            tick();
        end
        chk("bp_accepted", n_acc - base, DEPTH);
        chk("bp_in_stall", bus.in_stall, 1);
        bus.ss_stall = 1'b0;
        for (int c = 0; c < 400 && (n_acc - base) < 40; c++) begin
            offer(8'(32'h20 + n_acc - base), 1'b0, 1'b0, $urandom, $urandom);
            tick();
        end
        chk("bp_total", n_acc - base, 40);
        drain("bp");

        // Stalled shader FIFO does not hold back a hit-only stream
        bus.sh_stall = 1'b1;
        base = n_acc;
        bp0  = n_bp;
        for (int c = 0; c < DEPTH; c++) begin
            offer(8'(32'h60 + n_acc - base), 1'b0, 1'b0, $urandom, $urandom);
            tick();
        end
        idle();
        chk("indep_accepted", n_acc - base, DEPTH);
        chk("indep_no_stall", n_bp - bp0, 0);
        repeat (LAT + 1 - DEPTH) tick();
        cnt = 0;
        for (int c = 0; c < DEPTH; c++) begin
            cnt += int'(bus.tarb_valid && bus.ss_valid);
            tick();
        end
        chk("indep_rate", cnt, DEPTH);
        drain("indep");

        // Reset with 10 rays in flight
        for (int c = 0; c < 10; c++) begin
            offer(8'(32'h80 + c), 1'b0, c[0], $urandom, $urandom);
            tick();
        end
        idle();
        rst = 1'b0;
        #1;
        chk("midrst_in_stall", bus.in_stall, 1);
        chk("midrst_valids", {bus.tarb_valid, bus.ss_valid, bus.sh_valid}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        qt.delete();
        qs.delete();
        qh.delete();
        rst_acc = n_acc;
        cnt = 0;
        repeat (LAT + 10) begin
            cnt += int'(bus.tarb_valid || bus.ss_valid || bus.sh_valid);
            tick();
        end
        chk("midrst_no_valid", cnt, 0);
        base = n_acc;
        bp0  = n_bp;
        for (int c = 0; c < DEPTH; c++) begin
            offer(8'(32'hA0 + n_acc - base), 1'b0, 1'b0, $urandom, $urandom);
            tick();
        end
        chk("midrst_credits", n_acc - base, DEPTH);
        chk("midrst_no_stall", n_bp - bp0, 0);
        drain("midrst");

        // Random stalls on all outputs, 50% miss
        base = n_acc;
        for (int c = 0; c < 60000 && (n_acc - base) < NRAND; c++) begin
            bus.tarb_stall = ($urandom_range(3) == 0);
            bus.ss_stall   = ($urandom_range(3) == 0);
            bus.sh_stall   = ($urandom_range(3) == 0);
            if ($urandom_range(4) != 0)
                offer(8'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
            else
                idle();
            tick();
        end
        chk("rand_count", n_acc - base, NRAND);
        drain("rand");
`ifdef SINT_STATS_EN
        chk("stat_total", stat_hits + stat_misses, 32'(n_acc - rst_acc));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
